// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: sequences the shared ALU / unified memory datapath,
// counts retired instructions and flags bad opcodes. Define MIPS_ADDI_EN to decode addi.
module multicycle_controller #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state,
  output logic             illegal_op,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_EXEC      = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EX   = 4'd10,
    S_ADDI_WB   = 4'd11
  } state_e;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h08;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pc_write, pc_write_cond, retire;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    retire        = 1'b0;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    RegDst        = 1'b0;
    MemtoReg      = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ALUOp         = 2'b00;
    PCSource      = 2'b00;
    illegal_op    = 1'b0;
    case (state_q)
      S_FETCH: begin
        MemRead  = 1'b1;
        ALUSrcB  = 2'b01;
        IRWrite  = mem_ready;
        pc_write = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        // Branch target is precomputed here while the opcode is decoded.
        ALUSrcB = 2'b11;
        case (opcode)
          OP_R:         state_d = S_EXEC;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
`ifdef MIPS_ADDI_EN
          OP_ADDI:      state_d = S_ADDI_EX;
`endif
          default: begin
            state_d    = S_FETCH;
            illegal_op = 1'b1;
          end
        endcase
      end
      S_MEM_ADDR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        if (opcode == OP_LW)      state_d = S_MEM_READ;
        else if (opcode == OP_SW) state_d = S_MEM_WRITE;
        else                      state_d = S_FETCH;
      end
      S_MEM_READ: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) state_d = S_MEM_WB;
      end
      S_MEM_WB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_MEM_WRITE: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) begin
          retire  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
        state_d = S_R_WB;
      end
      S_R_WB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA       = 1'b1;
        ALUOp         = 2'b01;
        pc_write_cond = 1'b1;
        PCSource      = 2'b01;
        retire        = 1'b1;
        state_d       = S_FETCH;
      end
      S_JUMP: begin
        pc_write = 1'b1;
        PCSource = 2'b10;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
`ifdef MIPS_ADDI_EN
      S_ADDI_EX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        state_d = S_ADDI_WB;
      end
      S_ADDI_WB: begin
        RegWrite = 1'b1;
        retire   = 1'b1;
        state_d  = S_FETCH;
      end
`endif
      default: state_d = S_FETCH;
    endcase

    pc_en = pc_write | (pc_write_cond & zero);
    cnt_d = retire ? cnt_q + CNT_W'(1) : cnt_q;

    // Reset silences the whole datapath combinationally, not just from the next edge.
    if (rst) begin
      pc_en      = 1'b0;
      IorD       = 1'b0;
      MemRead    = 1'b0;
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegDst     = 1'b0;
      MemtoReg   = 1'b0;
      RegWrite   = 1'b0;
      ALUSrcA    = 1'b0;
      ALUSrcB    = 2'b00;
      ALUOp      = 2'b00;
      PCSource   = 2'b00;
      illegal_op = 1'b0;
    end
  end

  assign state       = rst ? 4'd0 : state_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed scoreboard bench for multicycle_controller (CNT_W = 4 so the counter wrap is reachable).
module tb_multicycle_controller;
  localparam int CNT_W = 4;

  logic clk = 1'b0, rst = 1'b1, zero = 1'b0, mem_ready = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic pc_en, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, illegal_op;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] state;
  logic [CNT_W-1:0] instr_count;

  multicycle_controller #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource), .state(state),
    .illegal_op(illegal_op), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  // {pc_en, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op}
  logic [15:0] ctrl;
  assign ctrl = {pc_en, IorD, MemRead, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                 ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op};

  typedef struct {
    logic [3:0]       st;
    logic             mr;
    logic             z;
    logic [5:0]       op;
    logic [CNT_W-1:0] cnt;
  } item_t;

  item_t            q[$];
  int               errors = 0, checks = 0;
  logic [CNT_W-1:0] exp_cnt = '0;
  logic [5:0]       cur_op = 6'h00;

  function automatic logic [15:0] exp_ctrl(input logic [3:0] st, input logic mr, input logic z,
                                           input logic [5:0] op);
    logic legal;
    legal = (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h02);
`ifdef MIPS_ADDI_EN
    legal = legal || (op == 6'h08);
`endif
    case (st)
      4'd0:  return {mr, 1'b0, 1'b1, 1'b0, mr, 3'b000, 1'b0, 2'b01, 2'b00, 2'b00, 1'b0};
      4'd1:  return {9'b0, 2'b11, 2'b00, 2'b00, ~legal};
      4'd2:  return {8'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0};
      4'd3:  return 16'b0110_0000_0000_0000;
      4'd4:  return 16'b0000_0011_0000_0000;
      4'd5:  return 16'b0101_0000_0000_0000;
      4'd6:  return {8'b0, 1'b1, 2'b00, 2'b10, 2'b00, 1'b0};
      4'd7:  return 16'b0000_0101_0000_0000;
      4'd8:  return {z, 7'b0, 1'b1, 2'b00, 2'b01, 2'b01, 1'b0};
      4'd9:  return {1'b1, 8'b0, 2'b00, 2'b00, 2'b10, 1'b0};
      4'd10: return {8'b0, 1'b1, 2'b10, 2'b00, 2'b00, 1'b0};
      4'd11: return 16'b0000_0001_0000_0000;
      default: return 16'b0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  task automatic push(input logic [3:0] st, input logic mr, input logic z, input bit ret);
    item_t it;
    it.st = st; it.mr = mr; it.z = z; it.op = cur_op; it.cnt = exp_cnt;
    q.push_back(it);
    if (ret) exp_cnt = exp_cnt + 1'b1;
  endtask

  // One instruction: fw/mw are wait cycles in FETCH and in the memory-access state.
  task automatic instr(input logic [5:0] op, input logic z, input int fw, input int mw);
    bit legal;
    cur_op = op;
    for (int i = 0; i < fw; i++) push(4'd0, 1'b0, 1'b1, 0);
    push(4'd0, 1'b1, 1'b1, 0);
    legal = (op == 6'h00) || (op == 6'h23) || (op == 6'h2B) || (op == 6'h04) || (op == 6'h02);
`ifdef MIPS_ADDI_EN
    legal = legal || (op == 6'h08);
`endif
    push(4'd1, 1'b0, 1'b1, 0);
    if (legal) begin
      case (op)
        6'h23: begin
          push(4'd2, 1'b0, 1'b1, 0);
          for (int i = 0; i < mw; i++) push(4'd3, 1'b0, 1'b1, 0);
          push(4'd3, 1'b1, 1'b1, 0);
          push(4'd4, 1'b0, 1'b1, 1);
        end
        6'h2B: begin
          push(4'd2, 1'b0, 1'b1, 0);
          for (int i = 0; i < mw; i++) push(4'd5, 1'b0, 1'b1, 0);
          push(4'd5, 1'b1, 1'b1, 1);
        end
        6'h00: begin push(4'd6, 1'b0, 1'b1, 0); push(4'd7, 1'b0, 1'b1, 1); end
        6'h04: push(4'd8, 1'b0, z, 1);
        6'h02: push(4'd9, 1'b0, 1'b1, 1);
        default: begin push(4'd10, 1'b0, 1'b1, 0); push(4'd11, 1'b0, 1'b1, 1); end
      endcase
    end
  endtask

  task automatic drain();
    item_t it;
    while (q.size() > 0) begin
      it = q.pop_front();
      mem_ready = it.mr; zero = it.z; opcode = it.op;
      #1;
      chk("state", {12'b0, state}, {12'b0, it.st});
      chk("ctrl", ctrl, exp_ctrl(it.st, it.mr, it.z, it.op));
      chk("instr_count", {12'b0, instr_count}, {12'b0, it.cnt});
      @(negedge clk);
    end
  endtask

  initial begin
    // Reset held over the first edge
    @(negedge clk);
    mem_ready = 1'b1; zero = 1'b1;
    #1;
    chk("rst_state", {12'b0, state}, 16'h0);
    chk("rst_ctrl", ctrl, 16'h0);
    chk("rst_count", {12'b0, instr_count}, 16'h0);
    @(negedge clk);
    rst = 1'b0;

    instr(6'h23, 1'b1, 0, 0);   // lw, no waits
    instr(6'h2B, 1'b1, 0, 3);   // sw, three memory waits
    instr(6'h00, 1'b1, 0, 0);   // R-type
    instr(6'h04, 1'b1, 0, 0);   // beq taken
    instr(6'h04, 1'b0, 0, 0);   // beq not taken
    instr(6'h02, 1'b1, 0, 0);   // j
    instr(6'h3F, 1'b1, 0, 0);   // illegal
    instr(6'h08, 1'b1, 0, 0);   // addi (illegal unless enabled)
    instr(6'h23, 1'b1, 2, 1);   // lw with fetch and read stalls
    drain();

    // Abort a lw in MEM_READ with reset
    cur_op = 6'h23;
    push(4'd0, 1'b1, 1'b1, 0);
    push(4'd1, 1'b0, 1'b1, 0);
    push(4'd2, 1'b0, 1'b1, 0);
    push(4'd3, 1'b0, 1'b1, 0);
    drain();
    rst = 1'b1; mem_ready = 1'b1; zero = 1'b1;
    #1;
    chk("midrst_ctrl", ctrl, 16'h0);
    chk("midrst_state", {12'b0, state}, 16'h0);
    @(negedge clk);
    chk("midrst_ctrl2", ctrl, 16'h0);
    chk("midrst_count", {12'b0, instr_count}, 16'h0);
    rst = 1'b0;
    exp_cnt = '0;
    instr(6'h00, 1'b1, 0, 0);
    drain();

    // Sixteen more R-types from count 1 leave it at 1 again after wrap; 15 more reach 0
    for (int i = 0; i < 15; i++) instr(6'h00, 1'b1, 0, 0);
    drain();
    #1;
    chk("wrap_count", {12'b0, instr_count}, 16'h0);
    instr(6'h02, 1'b1, 0, 0);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Finite-state controller that sequences a multi-cycle MIPS datapath sharing one ALU and one unified instruction/data memory. It sits beside the register file, ALU, ALU control decoder and memory. From the latched opcode, the ALU `zero` flag and a memory-ready handshake, it drives every datapath enable and mux select. It also counts retired instructions and flags unsupported opcodes.

## Interface
Parameters:
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports:
- `clk`: input, 1 bit. Single clock; all state updates on the rising edge.
- `rst`: input, 1 bit. Reset is synchronous and active-high.
- `opcode`: input, 6 bits. `instruction[31:26]` from the instruction register.
- `zero`: input, 1 bit. ALU zero flag.
- `mem_ready`: input, 1 bit. Memory completes the current access this cycle.
- `pc_en`: output, 1 bit. PC load enable, equal to `PCWrite | (PCWriteCond & zero)`.
- `IorD`: output, 1 bit. Memory address source: 0 = PC, 1 = ALUOut.
- `MemRead`: output, 1 bit. Memory read request.
- `MemWrite`: output, 1 bit. Memory write request.
- `IRWrite`: output, 1 bit. Instruction register load.
- `RegDst`: output, 1 bit. Write-register select: 1 = rd, 0 = rt.
- `MemtoReg`: output, 1 bit. Write-data select: 1 = MDR, 0 = ALUOut.
- `RegWrite`: output, 1 bit. Register file write enable.
- `ALUSrcA`: output, 1 bit. ALU A operand: 0 = PC, 1 = register A.
- `ALUSrcB`: output, 2 bits. ALU B operand: 00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `ALUOp`: output, 2 bits. To the ALU control decoder: 00 = add, 01 = sub, 10 = funct.
- `PCSource`: output, 2 bits. Next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `state`: output, 4 bits. Current state encoding, for debug.
- `illegal_op`: output, 1 bit. One-cycle pulse on an unsupported opcode.
- `instr_count`: output, `CNT_W` bits. Number of instructions retired.

## Operation
State encodings:
- FETCH = 0, DECODE = 1, MEM_ADDR = 2, MEM_READ = 3, MEM_WB = 4, MEM_WRITE = 5, EXEC = 6, R_WB = 7, BRANCH = 8, JUMP = 9, ADDI_EX = 10, ADDI_WB = 11.

Outputs per state (any output not listed is 0):
- FETCH:
  - MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 01, ALUOp = 00, PCSource = 00.
  - IRWrite = `mem_ready`; PCWrite = `mem_ready`.
  - Next state: DECODE if `mem_ready`, else stay in FETCH.
- DECODE:
  - ALUSrcA = 0, ALUSrcB = 11, ALUOp = 00 (branch target computed into ALUOut).
  - Next state by opcode:
    - 0x00 → EXEC
    - 0x23 (lw) → MEM_ADDR
    - 0x2B (sw) → MEM_ADDR
    - 0x04 (beq) → BRANCH
    - 0x02 (j) → JUMP
    - 0x08 (addi, see Configuration) → ADDI_EX
    - anything else → FETCH, with `illegal_op` = 1 for this cycle.
- MEM_ADDR: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Next state: MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ: MemRead = 1, IorD = 1. Next state: MEM_WB if `mem_ready`, else hold.
- MEM_WB: RegDst = 0, MemtoReg = 1, RegWrite = 1. Next state: FETCH.
- MEM_WRITE: MemWrite = 1, IorD = 1. Next state: FETCH if `mem_ready`, else hold.
- EXEC: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 10. Next state: R_WB.
- R_WB: RegDst = 1, MemtoReg = 0, RegWrite = 1. Next state: FETCH.
- BRANCH: ALUSrcA = 1, ALUSrcB = 00, ALUOp = 01, PCWriteCond = 1, PCSource = 01. Next state: FETCH.
- JUMP: PCWrite = 1, PCSource = 10. Next state: FETCH.
- ADDI_EX: ALUSrcA = 1, ALUSrcB = 10, ALUOp = 00. Next state: ADDI_WB.
- ADDI_WB: RegDst = 0, MemtoReg = 0, RegWrite = 1. Next state: FETCH.

Outputs are decoded combinationally from `state`. `mem_ready`, `zero` and `opcode` gate them only where listed above. `opcode` is sampled only in DECODE and MEM_ADDR. The datapath must keep IR stable until the next FETCH.

Retirement and counting:
- `instr_count` increments by 1 on the final cycle of an instruction:
  - MEM_WB, R_WB, BRANCH, JUMP, ADDI_WB;
  - MEM_WRITE, only in the cycle where `mem_ready` = 1.
- The counter wraps modulo 2^`CNT_W` with no saturation.
- Illegal opcodes are not counted.
- A beq counts as retired whether or not the branch is taken.

## Timing
- Reset:
  - While `rst` = 1, every control output is forced to 0, including `pc_en`, `illegal_op` and every mux select.
  - On the first edge with `rst` = 1: `state` = FETCH and `instr_count` = 0.
  - The first FETCH cycle is the first cycle after `rst` deasserts.
- A reset that arrives mid-instruction aborts it. The partial instruction is not counted and no further write occurs after that edge.
- Latency with `mem_ready` held at 1, in cycles:
  - lw 5, sw 4, R-type 4, addi 4, beq 3, j 3.
  - Illegal opcode: 2 (FETCH then DECODE).
- Each cycle with `mem_ready` = 0 in FETCH, MEM_READ or MEM_WRITE adds exactly one cycle.
  - MemRead or MemWrite stays asserted throughout the wait.
  - IRWrite and pc_en stay 0 throughout the wait.
- `mem_ready` is ignored in every other state.
- `pc_en` in BRANCH depends combinationally on `zero` in the same cycle.

## Configuration
- `MIPS_ADDI_EN` defined:
  - Opcode 0x08 decodes to ADDI_EX → ADDI_WB.
- `MIPS_ADDI_EN` not defined:
  - Opcode 0x08 is illegal: DECODE → FETCH with `illegal_op` pulsed.
  - States 10 and 11 are unreachable. If `state` is ever forced to either, the next state is FETCH.

## Test plan
- Reset, then lw (opcode 0x23) with `mem_ready` = 1:
  - `state` goes 0, 1, 2, 3, 4, 0.
  - RegWrite = 1 and MemtoReg = 1 only in state 4.
  - `instr_count` reaches 1.
- sw with `mem_ready` low for 3 cycles in MEM_WRITE:
  - MemWrite stays high for 4 cycles.
  - Total latency is 7 cycles.
  - `instr_count` increments once.
- beq in BRANCH:
  - `zero` = 1 → `pc_en` = 1, PCSource = 01.
  - `zero` = 0 → `pc_en` = 0.
  - Both cases count.
- Opcode 0x3F:
  - `illegal_op` pulses in DECODE and `state` returns to 0.
  - `instr_count` is unchanged.
- Opcode 0x08:
  - With `MIPS_ADDI_EN`: 4 cycles, RegWrite = 1 and RegDst = 0 in state 11.
  - Without it: behaves as illegal.
- `rst` asserted while in MEM_READ:
  - All outputs are 0 during reset; `state` = 0 and `instr_count` = 0 afterwards.
- Counter wrap: with `CNT_W` = 4, 16 R-type instructions → `instr_count` wraps to 0.
